// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_TOGGLE  = 1'b1;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/config inputs and level/strobe outputs of the pulse stretcher.
interface pulse_stretcher_if #(
  parameter int CNT_W = 8
);

  logic             pulse_in;
  logic             mode;
  logic             retrig_en;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] holdoff;
  logic             level_out;
  logic             busy;
  logic             done_pulse;
  logic             drop_pulse;

  modport master (
    output pulse_in, mode, retrig_en, width, holdoff,
    input  level_out, busy, done_pulse, drop_pulse
  );

  modport slave (
    input  pulse_in, mode, retrig_en, width, holdoff,
    output level_out, busy, done_pulse, drop_pulse
  );

endinterface

// File: rtl/pulse_stretcher_load_down_counter.sv
// Loadable down-counter that saturates at zero and flags it.
module load_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle triggers into one-shot or toggled levels.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | waiting for a trigger; mode is sampled here
//   ST_ACTIVE  | one-shot level high, counting down the width
//   ST_HOLDOFF | dead time after an output event; triggers are dropped
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               reset_n,
  pulse_stretcher_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             level_q, level_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             mode_q, mode_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;

  logic [CNT_W-1:0] width_ld;
  logic [CNT_W-1:0] holdoff_ld;
  logic             holdoff_nz;

  // A width of zero behaves as one cycle; counts load as (cycles - 1).
  assign width_ld   = (bus.width == '0) ? '0 : (bus.width - ONE);
  assign holdoff_ld = bus.holdoff - ONE;
  assign holdoff_nz = (bus.holdoff != '0);

  load_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // Next-state, counter control and next output values.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    done_d       = 1'b0;
    drop_d       = 1'b0;
    mode_d       = mode_q;
    cnt_load     = 1'b0;
    cnt_load_val = width_ld;
    cnt_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        mode_d = bus.mode;
        if (bus.pulse_in) begin
          if (bus.mode == MODE_ONESHOT) begin
            state_d  = ST_ACTIVE;
            level_d  = 1'b1;
            cnt_load = 1'b1;
          end else begin
            level_d = ~level_q;
            if (holdoff_nz) begin
              state_d      = ST_HOLDOFF;
              cnt_load     = 1'b1;
              cnt_load_val = holdoff_ld;
            end
          end
        end else if ((mode_q == MODE_TOGGLE) && (bus.mode == MODE_ONESHOT)) begin
          // Leaving toggle mode releases any level left high, silently.
          level_d = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (bus.pulse_in && bus.retrig_en) begin
          cnt_load = 1'b1;
        end else begin
          drop_d = bus.pulse_in;
          if (cnt_zero) begin
            level_d = 1'b0;
            done_d  = 1'b1;
            if (holdoff_nz) begin
              state_d      = ST_HOLDOFF;
              cnt_load     = 1'b1;
              cnt_load_val = holdoff_ld;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end

      ST_HOLDOFF: begin
        drop_d = bus.pulse_in;
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        level_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      mode_q  <= MODE_ONESHOT;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      drop_q  <= drop_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.level_out  = level_q;
  assign bus.busy       = busy_q;
  assign bus.done_pulse = done_q;
  assign bus.drop_pulse = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher with a cycle-count reference model.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic reset_n;

  pulse_stretcher_if #(.CNT_W(8)) bus ();

  pulse_stretcher #(.CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic level;
    logic busy;
    logic done;
    logic drop;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: remaining high cycles and remaining dead cycles.
  int act_rem = 0;
  int ho_rem  = 0;
  bit lvl     = 1'b0;

  task automatic model_step();
    int w;
    bit p, done, drop;
    w    = (bus.width == 0) ? 1 : int'(bus.width);
    p    = bus.pulse_in;
    done = 1'b0;
    drop = 1'b0;
    if (act_rem > 0) begin
      if (p && bus.retrig_en) begin
        act_rem = w;
      end else begin
        drop    = p;
        act_rem = act_rem - 1;
        if (act_rem == 0) begin
          lvl    = 1'b0;
          done   = 1'b1;
          ho_rem = int'(bus.holdoff);
        end
      end
    end else if (ho_rem > 0) begin
      drop   = p;
      ho_rem = ho_rem - 1;
    end else if (p) begin
      if (bus.mode == 1'b0) begin
        lvl     = 1'b1;
        act_rem = w;
      end else begin
        lvl    = ~lvl;
        ho_rem = int'(bus.holdoff);
      end
    end else if (bus.mode == 1'b0) begin
      lvl = 1'b0;
    end
    q_exp.push_back('{level: lvl, busy: (act_rem > 0) || (ho_rem > 0),
                      done: done, drop: drop});
  endtask

  // Advance the model on every clock edge; reset clears model and queue.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_rem = 0;
      ho_rem  = 0;
      lvl     = 1'b0;
      q_exp.delete();
    end else begin
      model_step();
    end
  end

  // Monitor: compare registered outputs mid-cycle against the queue.
  always @(negedge clk) begin
    exp_t e, g;
    cyc = cyc + 1;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      g = '{level: bus.level_out, busy: bus.busy,
            done: bus.done_pulse, drop: bus.drop_pulse};
      n_cmp = n_cmp + 1;
      if (g !== e) begin
        n_bad = n_bad + 1;
        $display("FAIL outputs cycle %0d: got lvl/busy/done/drop=%b%b%b%b required %b%b%b%b",
                 cyc, g.level, g.busy, g.done, g.drop, e.level, e.busy, e.done, e.drop);
      end
    end
  end

  task automatic step(input bit p);
    bus.pulse_in = p;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic cfg(input bit m, input bit r, input int w, input int h);
    bus.mode      = m;
    bus.retrig_en = r;
    bus.width     = 8'(w);
    bus.holdoff   = 8'(h);
  endtask

  initial begin
    bus.pulse_in = 1'b0;
    cfg(1'b0, 1'b0, 5, 0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    // One-shot, width 5, no holdoff.
    step(1'b1); idle(10);

    // Retrigger extends; without retrigger the second pulse is dropped.
    cfg(1'b0, 1'b1, 4, 0);
    step(1'b1); step(1'b0); step(1'b1); idle(10);
    cfg(1'b0, 1'b0, 4, 0);
    step(1'b1); step(1'b0); step(1'b1); idle(10);

    // Holdoff: middle pulse dropped, later one accepted.
    cfg(1'b0, 1'b0, 2, 3);
    step(1'b1); idle(3); step(1'b1); step(1'b0); step(1'b1); idle(10);

    // Toggle mode with holdoff, then back to one-shot releases the level.
    cfg(1'b1, 1'b0, 2, 2);
    step(1'b1); step(1'b1); idle(2); step(1'b1); idle(4);
    step(1'b1); idle(4);
    cfg(1'b0, 1'b0, 2, 0);
    idle(4);

    // Boundaries: width 0, width 255, retrigger exactly at expiry.
    cfg(1'b0, 1'b0, 0, 0);
    step(1'b1); idle(4);
    cfg(1'b0, 1'b0, 255, 0);
    step(1'b1); idle(260);
    cfg(1'b0, 1'b1, 3, 0);
    step(1'b1); idle(2); step(1'b1); idle(6);
    cfg(1'b0, 1'b0, 1, 255);
    step(1'b1); idle(260);

    // Asynchronous reset in the middle of a one-shot.
    cfg(1'b0, 1'b0, 5, 0);
    step(1'b1); step(1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if ({bus.level_out, bus.busy, bus.done_pulse, bus.drop_pulse} !== 4'b0000) begin
      n_bad = n_bad + 1;
      $display("FAIL async_reset: got %b%b%b%b required 0000",
               bus.level_out, bus.busy, bus.done_pulse, bus.drop_pulse);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(1'b1); idle(8);

    // Randomized traffic; width/holdoff change every cycle to exercise load-point sampling.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 60) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 15) == 0) bus.retrig_en = ~bus.retrig_en;
      bus.width   = 8'($urandom_range(0, 7));
      bus.holdoff = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      step($urandom_range(0, 3) == 0);
    end
    bus.pulse_in = 1'b0;
    idle(20);

    if (n_cmp < 12) begin
      n_bad = n_bad + 1;
      $display("FAIL compare_count: got %0d required at least 12", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
